// File: rtl/vec_pkg.sv
// Shared vector types and constants for the vector store path.
// Used by vec_store_serializer and vec_lane_mux.
package vec_pkg;

  localparam int VEC_LANES  = 24;
  localparam int VEC_LANE_W = 8;
  localparam int VEC_W      = VEC_LANES * VEC_LANE_W;

  typedef logic [VEC_W-1:0]      vec_t;
  typedef logic [VEC_LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } vst_state_t;

endpackage

// File: rtl/vec_lane_mux.sv
// Combinational LANES:1 lane selector. Out-of-range indices return zero.
// Kept generic so a vector load/extract unit can reuse it.
module vec_lane_mux
  import vec_pkg::*;
#(
  parameter int LANES  = VEC_LANES,
  parameter int LANE_W = VEC_LANE_W,
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic [LANES*LANE_W-1:0] vec,
  input  logic [IDX_W-1:0]        idx,
  output logic [LANE_W-1:0]       lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == IDX_W'(i)) lane = vec[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/vec_store_serializer.sv
// Vector store engine: drains one captured vector to byte-wide memory, lane 0 first.
// Define VEC_STORE_STRIDE_EN to add the in_stride port (default build: stride fixed at 1).
//
// state | meaning
// IDLE  | in_ready=1, waiting for a store request
// WRITE | presenting lane idx to memory, advancing on mem_ready
// DONE  | one-cycle done pulse, then back to IDLE
module vec_store_serializer
  import vec_pkg::*;
#(
  parameter int LANES  = VEC_LANES,
  parameter int LANE_W = VEC_LANE_W,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [ADDR_W-1:0]       in_addr,
`ifdef VEC_STORE_STRIDE_EN
  input  logic [ADDR_W-1:0]       in_stride,
`endif
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  vst_state_t               state;
  logic [IDX_W-1:0]         idx;
  logic [LANES*LANE_W-1:0]  vec_q;
  logic [ADDR_W-1:0]        addr_q;

`ifdef VEC_STORE_STRIDE_EN
  logic [ADDR_W-1:0]        stride_q;
`else
  localparam logic [ADDR_W-1:0] stride_q = ADDR_W'(1);
`endif

  // Address is accumulated beat by beat, so no multiplier is needed for strides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      vec_q    <= '0;
      addr_q   <= '0;
`ifdef VEC_STORE_STRIDE_EN
      stride_q <= ADDR_W'(1);
`endif
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            vec_q    <= in_data;
            addr_q   <= in_addr;
            idx      <= '0;
`ifdef VEC_STORE_STRIDE_EN
            stride_q <= in_stride;
`endif
            state    <= WRITE;
            in_ready <= 1'b0;
            mem_we   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            if (idx == LAST_IDX) begin
              state  <= DONE;
              mem_we <= 1'b0;
              done   <= 1'b1;
            end else begin
              idx    <= idx + IDX_W'(1);
              addr_q <= addr_q + stride_q;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          mem_we   <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = addr_q;

  vec_lane_mux #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .IDX_W  (IDX_W)
  ) u_lane_mux (
    .vec  (vec_q),
    .idx  (idx),
    .lane (mem_wdata)
  );

endmodule

// File: doc/vec_store_serializer.md
Name: vec_store_serializer

Overview:
- Write-side counterpart of the vector-scalar ALU.
- Accepts one packed 192-bit vector result (24 lanes x 8 bit) plus a base byte address over a valid/ready handshake.
- Drains the vector to byte-wide data memory, one lane per accepted memory beat, lane 0 first.
- Sits between the vector ALU writeback path and data memory; it is the store engine for vector registers.

Parameters:
- LANES, 24, number of lanes per vector.
- LANE_W, 8, bits per lane; in_data width = LANES*LANE_W.
- ADDR_W, 32, memory byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  vector store request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  LANES*LANE_W  packed vector; lane i = bits [i*LANE_W +: LANE_W].
- in_addr  input  ADDR_W  base byte address for lane 0.
- mem_we  output  1  memory write request.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  LANE_W  write data.
- mem_ready  input  1  memory accepts the current beat this cycle.
- busy  output  1  high while in WRITE or DONE.
- done  output  1  one-cycle pulse after the last lane is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE and lane index to 0.
  - in_ready=1 after reset; mem_we, done and busy are 0; mem_addr and mem_wdata are 0.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE.
  - Beats already accepted by memory are not undone.
  - done is not pulsed.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1, mem_we=0.
  - When in_valid && in_ready, capture in_data, in_addr and idx=0, then go to WRITE.
- WRITE:
  - in_ready=0, mem_we=1.
  - mem_addr = base + idx, modulo 2^ADDR_W; wrap-around is silent.
  - mem_wdata = lane[idx].
  - On mem_ready: if idx==LANES-1, go to DONE; otherwise idx increments.
  - While mem_we && !mem_ready, mem_addr and mem_wdata hold stable, with no limit on stall length.
- DONE:
  - done=1 for exactly one cycle, in_ready=0, mem_we=0.
  - Next state is IDLE.
- Timing:
  - Minimum request-to-request interval is LANES+2 cycles: accept, then LANES beats, then DONE.
  - The first mem_we appears the cycle after acceptance.
- in_data and in_addr are sampled only on the accept cycle; later changes are ignored.
- mem_ready is ignored outside WRITE.
- in_valid while busy is held off by in_ready=0; no request is dropped.
- Outputs are driven from registers or from state only; there is no combinational path from in_* to mem_*.

Optional Feature:
- Macro: VEC_STORE_STRIDE_EN.
- When defined:
  - Extra input port in_stride [ADDR_W] is sampled on accept.
  - mem_addr = base + idx*stride, computed by an accumulating adder, not a multiplier.
  - Stride 0 writes all lanes to the same address, in order.
  - Arithmetic wraps modulo 2^ADDR_W.
- When not defined: the port is absent and the stride is fixed at 1.

Decomposition:
- Shared package vec_pkg:
  - Constants VEC_LANES=24, VEC_LANE_W=8, VEC_W=192.
  - typedef vec_t (logic [VEC_W-1:0]).
  - typedef lane_t (logic [VEC_LANE_W-1:0]).
  - enum vst_state_t {IDLE, WRITE, DONE}.
- One natural sub-module: vec_lane_mux, a combinational LANES:1 lane selector indexed by idx. It is reusable by a future vector load/extract unit.
- The FSM, index counter and address generator stay in the top module.

Test Plan:
- Reset with in_valid=1:
  - in_ready=1, mem_we=0, done=0.
  - No acceptance until rst_n=1 and the next edge.
- Single store, mem_ready=1 constantly:
  - Stimulus: in_data with lane i = i+1, in_addr=0x100.
  - Expect 24 consecutive beats with addr 0x100..0x117 and data 0x01..0x18.
  - done pulses on cycle 26 after accept; in_ready returns the cycle after.
- Backpressure:
  - Stimulus: mem_ready=0 for 3 cycles at lane 5.
  - Expect mem_addr=base+5 and mem_wdata=lane5 held stable for 4 cycles, then normal progression.
- Address wrap:
  - Stimulus: in_addr=0xFFFF_FFFE.
  - Expect lanes 0..2 at 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Reset mid-store:
  - Stimulus: assert rst_n=0 at lane 10.
  - Expect mem_we=0 next cycle, no done pulse, and a new request accepted with idx restarting at 0.
- With VEC_STORE_STRIDE_EN, stride=4, base=0x200:
  - Expect addresses 0x200, 0x204, ... up to 0x25C.
  - Stride 0 gives all 24 beats at 0x200 in lane order.
